truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Hardware response checker for combinational partitions under approximation.
- Sweeps every input vector 0..2^N_IN-1 into the partition under test and samples the partition's outputs.
- Compares each output against a golden truth table held in a loadable internal memory.
- Accumulates error metrics (mismatch count, Hamming-distance sum, max absolute error) in hardware, so sweeps of exact and approximate partitions need no text dumps.

Parameters:
- N_IN, 7, input width of partition under test; sweep length 2^N_IN.
- N_OUT, 4, output width of partition under test.
- SETTLE, 1, idle cycles between driving a vector and sampling outputs; legal range 0..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse begins a sweep; ignored unless in IDLE or DONE.
- golden_we  input  1  golden memory write enable; ignored while busy.
- golden_addr  input  N_IN  golden memory write address (input vector).
- golden_data  input  N_OUT  expected output for golden_addr.
- pi_out  output  N_IN  vector driven to partition under test.
- po_in  input  N_OUT  partition response.
- busy  output  1  high in DRIVE/SETTLE/COMPARE.
- done  output  1  high in DONE; sticky until next start or rst.
- err_count  output  N_IN+1  number of vectors with po_in != golden.
- hd_sum  output  N_IN+ceil(log2(N_OUT+1))  sum of popcount(po_in XOR golden); 10 bits at defaults.
- max_abs_err  output  N_OUT  max unsigned |po_in - golden| over the sweep.
- first_err_idx  output  N_IN  index of first mismatching vector.
- first_err_valid  output  1  first_err_idx holds a valid index.

Behaviour:
- Reset: state IDLE; pi_out=0, busy=0, done=0, err_count=0, hd_sum=0, max_abs_err=0, first_err_idx=0, first_err_valid=0. Golden memory is not cleared and keeps its contents across rst; contents are undefined after power-up.
- Golden write: if golden_we=1 in IDLE or DONE, mem[golden_addr] <= golden_data at the clock edge.
- FSM states: IDLE, DRIVE, SETTLE, COMPARE, DONE.
- IDLE/DONE + start:
  - Clear all metric outputs and first_err_valid; clear done; idx=0.
  - Go to DRIVE.
  - If start and golden_we are both high, the write happens and the sweep starts.
- DRIVE (1 cycle):
  - pi_out <= idx; settle counter loaded.
  - Go to SETTLE if SETTLE>0, else COMPARE.
- SETTLE (exactly SETTLE cycles): pi_out held; then COMPARE.
- COMPARE (1 cycle): sample po_in against mem[idx]; pi_out still held.
  - On mismatch: err_count += 1; hd_sum += popcount(diff); max_abs_err = max(max_abs_err, |po_in - golden|).
  - On the first mismatch only: first_err_idx <= idx, first_err_valid <= 1.
  - If idx = 2^N_IN-1, go to DONE; else idx += 1 and go to DRIVE.
  - The index counter is N_IN+1 bits wide internally so the terminal test never wraps.
- Timing:
  - Per vector: 2+SETTLE cycles.
  - Full sweep: 2^N_IN*(2+SETTLE) cycles from the first DRIVE; 384 at defaults.
  - done rises the cycle after the last COMPARE.
- Outputs are registered and update on the clock edge ending COMPARE. Metrics are stable and valid while done=1.
- Saturation is not required: widths are sized for the worst case (all vectors wrong, all bits wrong).
- start while busy: ignored, with no effect on the sweep.
- golden_we while busy: ignored; memory is unchanged.
- rst mid-sweep: next cycle is IDLE with all outputs at reset values; golden memory is retained.
- pi_out in DONE: holds the last vector, 2^N_IN-1.

Test Plan:
- Load golden = (a+b) truth table for a 7-bit exact adder partition; feed po_in from an exact model with SETTLE=1 -> done at cycle 384 after start; err_count=0, hd_sum=0, max_abs_err=0, first_err_valid=0.
- Same golden; model forces po_in[0]=0 -> err_count=64, hd_sum=64, max_abs_err=1, first_err_idx = lowest index whose golden bit0=1.
- Model inverts all 4 output bits on every vector -> err_count=128, hd_sum=512 (no overflow in 10 bits), max_abs_err=15, first_err_idx=0.
- Assert rst at cycle 100 of a sweep -> next cycle busy=0, done=0, all metrics 0; a second start with no reload reproduces the original results (golden retained).
- Pulse start and golden_we mid-sweep -> sweep timing unchanged and memory unmodified; a start pulse in DONE clears metrics and reruns with identical results.
- SETTLE=0 and SETTLE=3 -> sweep takes 256 and 640 cycles; pi_out is stable for 2 and 5 cycles per vector.

Source files
------------

// File: rtl/truth_table_checker_if.sv
// Bus between the truth-table checker and its environment.
//   master : checker side. Drives pi_out, busy, done and the error metrics.
//            Receives start, the golden-memory write port and po_in.
//   slave  : environment side. It drives start, the golden writes and the
//            partition response, and it observes everything else.
interface truth_table_checker_if #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 4
);
  localparam int HD_W = N_IN + $clog2(N_OUT + 1);

  logic              start;
  logic              golden_we;
  logic [N_IN-1:0]   golden_addr;
  logic [N_OUT-1:0]  golden_data;
  logic [N_IN-1:0]   pi_out;
  logic [N_OUT-1:0]  po_in;
  logic              busy;
  logic              done;
  logic [N_IN:0]     err_count;
  logic [HD_W-1:0]   hd_sum;
  logic [N_OUT-1:0]  max_abs_err;
  logic [N_IN-1:0]   first_err_idx;
  logic              first_err_valid;

  modport master (
    input  start, golden_we, golden_addr, golden_data, po_in,
    output pi_out, busy, done, err_count, hd_sum, max_abs_err,
           first_err_idx, first_err_valid
  );

  modport slave (
    output start, golden_we, golden_addr, golden_data, po_in,
    input  pi_out, busy, done, err_count, hd_sum, max_abs_err,
           first_err_idx, first_err_valid
  );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive response checker for a combinational partition.
// The checker drives each input vector 0..2^N_IN-1 onto pi_out. It waits
// SETTLE cycles and then compares po_in with a loadable golden truth table.
// Across the sweep it accumulates the mismatch count, the Hamming-distance
// sum, the maximum absolute error and the index of the first mismatch.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : truth_table_checker_if.master. It carries start and the golden
//              write port, pi_out/po_in to and from the partition, busy/done
//              status and the error metrics.
module truth_table_checker #(
  parameter int N_IN   = 7,
  parameter int N_OUT  = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  truth_table_checker_if.master  bus
);
  localparam int              HD_W     = N_IN + $clog2(N_OUT + 1);
  localparam int              PC_W     = $clog2(N_OUT + 1);
  localparam logic [N_IN:0]   IDX_LAST = (N_IN + 1)'((2 ** N_IN) - 1);
  localparam logic [3:0]      SETTLE_L = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [N_OUT-1:0]  r_mem [2 ** N_IN];
  logic [N_IN:0]     r_idx;
  logic [3:0]        r_cnt;
  logic [N_IN-1:0]   r_pi;
  logic [N_IN:0]     r_err;
  logic [HD_W-1:0]   r_hd;
  logic [N_OUT-1:0]  r_max;
  logic [N_IN-1:0]   r_fidx;
  logic              r_fvalid;

  logic              w_idle_like;
  logic [N_OUT-1:0]  w_gold;
  logic [N_OUT-1:0]  w_diff;
  logic [N_OUT-1:0]  w_abs;
  logic [PC_W-1:0]   w_pop;
  logic              w_mismatch;
  logic              w_last;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_gold      = r_mem[r_idx[N_IN-1:0]];
  assign w_diff      = bus.po_in ^ w_gold;
  assign w_mismatch  = |w_diff;
  assign w_abs       = (bus.po_in >= w_gold) ? (bus.po_in - w_gold) : (w_gold - bus.po_in);
  // The index register is one bit wider than the vector, so this
  // terminal test is exact and never wraps.
  assign w_last      = (r_idx == IDX_LAST);

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      w_pop = w_pop + PC_W'(w_diff[i]);
    end
  end

  // Golden memory has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (bus.golden_we && w_idle_like) begin
      r_mem[bus.golden_addr] <= bus.golden_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (bus.start) w_state_next = S_DRIVE;
      S_DRIVE:        w_state_next = (SETTLE == 0) ? S_COMPARE : S_SETTLE;
      S_SETTLE:       if (r_cnt <= 4'd1) w_state_next = S_COMPARE;
      S_COMPARE:      w_state_next = w_last ? S_DONE : S_DRIVE;
      default:        w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_pi     <= '0;
      r_err    <= '0;
      r_hd     <= '0;
      r_max    <= '0;
      r_fidx   <= '0;
      r_fvalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_idx    <= '0;
            r_err    <= '0;
            r_hd     <= '0;
            r_max    <= '0;
            r_fidx   <= '0;
            r_fvalid <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_pi  <= r_idx[N_IN-1:0];
          r_cnt <= SETTLE_L;
        end
        S_SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_COMPARE: begin
          if (w_mismatch) begin
            r_err <= r_err + 1'b1;
            r_hd  <= r_hd + HD_W'(w_pop);
            if (w_abs > r_max) r_max <= w_abs;
            if (!r_fvalid) begin
              r_fidx   <= r_idx[N_IN-1:0];
              r_fvalid <= 1'b1;
            end
          end
          if (!w_last) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pi_out          = r_pi;
  assign bus.busy            = (r_state == S_DRIVE) || (r_state == S_SETTLE) || (r_state == S_COMPARE);
  assign bus.done            = (r_state == S_DONE);
  assign bus.err_count       = r_err;
  assign bus.hd_sum          = r_hd;
  assign bus.max_abs_err     = r_max;
  assign bus.first_err_idx   = r_fidx;
  assign bus.first_err_valid = r_fvalid;
endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker. There are three instances with SETTLE=0, 1
// and 3. Each partition response is computed from its pi_out by a behavioural
// adder model, in exact, bit0-stuck-at-0 or all-bits-inverted form. The
// expected sweep results are pushed to a scoreboard at start and popped at done.
module tb_truth_table_checker;
  localparam int N_IN  = 7;
  localparam int N_OUT = 4;

  typedef struct {
    int err; int hd; int mx; int fidx; int fvalid;
    int cycles; int run5; int busy; int done; int pi;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, st0, st1, st3, g_we;
  logic [N_IN-1:0]  g_addr;
  logic [N_OUT-1:0] g_data;
  int               mode;
  int               checks = 0;
  int               errors = 0;
  res_t             sb[$];

  truth_table_checker_if #(.N_IN(N_IN), .N_OUT(N_OUT)) b0 ();
  truth_table_checker_if #(.N_IN(N_IN), .N_OUT(N_OUT)) b1 ();
  truth_table_checker_if #(.N_IN(N_IN), .N_OUT(N_OUT)) b3 ();

  function automatic logic [3:0] adder(logic [6:0] v);
    return v[6:3] + {1'b0, v[2:0]};
  endfunction

  function automatic logic [3:0] resp(int m, logic [6:0] v);
    case (m)
      1:       return adder(v) & 4'b1110;
      2:       return ~adder(v);
      default: return adder(v);
    endcase
  endfunction

  assign b0.start = st0;  assign b1.start = st1;  assign b3.start = st3;
  assign b0.golden_we = g_we;   assign b1.golden_we = g_we;   assign b3.golden_we = g_we;
  assign b0.golden_addr = g_addr; assign b1.golden_addr = g_addr; assign b3.golden_addr = g_addr;
  assign b0.golden_data = g_data; assign b1.golden_data = g_data; assign b3.golden_data = g_data;
  assign b0.po_in = resp(mode, b0.pi_out);
  assign b1.po_in = resp(mode, b1.pi_out);
  assign b3.po_in = resp(mode, b3.pi_out);

  truth_table_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  truth_table_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  truth_table_checker #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

  function automatic res_t observe(int which);
    res_t o = '{default: 0};
    case (which)
      0: begin
        o.err = int'(b0.err_count); o.hd = int'(b0.hd_sum); o.mx = int'(b0.max_abs_err);
        o.fidx = int'(b0.first_err_idx); o.fvalid = int'(b0.first_err_valid);
        o.busy = int'(b0.busy); o.done = int'(b0.done); o.pi = int'(b0.pi_out);
      end
      1: begin
        o.err = int'(b1.err_count); o.hd = int'(b1.hd_sum); o.mx = int'(b1.max_abs_err);
        o.fidx = int'(b1.first_err_idx); o.fvalid = int'(b1.first_err_valid);
        o.busy = int'(b1.busy); o.done = int'(b1.done); o.pi = int'(b1.pi_out);
      end
      default: begin
        o.err = int'(b3.err_count); o.hd = int'(b3.hd_sum); o.mx = int'(b3.max_abs_err);
        o.fidx = int'(b3.first_err_idx); o.fvalid = int'(b3.first_err_valid);
        o.busy = int'(b3.busy); o.done = int'(b3.done); o.pi = int'(b3.pi_out);
      end
    endcase
    return o;
  endfunction

  // Reference results for a full sweep, built from the behavioural model.
  function automatic res_t model_sweep(int m, int s);
    res_t e = '{default: 0};
    logic [6:0] v;
    logic [3:0] g, r;
    int ad;
    for (int i = 0; i < 128; i++) begin
      v = 7'(i);
      g = adder(v);
      r = resp(m, v);
      if (r != g) begin
        ad = (r > g) ? int'(r) - int'(g) : int'(g) - int'(r);
        e.err++;
        e.hd += $countones(r ^ g);
        if (ad > e.mx) e.mx = ad;
        if (e.fvalid == 0) begin e.fidx = i; e.fvalid = 1; end
      end
    end
    e.cycles = 128 * (2 + s);
    e.run5   = 2 + s;
    return e;
  endfunction

  task automatic set_start(int which, logic v);
    case (which)
      0:       st0 = v;
      1:       st1 = v;
      default: st3 = v;
    endcase
  endtask

  // Pulse start and wait for done, with a bounded wait. At cycle inj_at the
  // task also pulses start and a golden write (addr 1 <- 0).
  task automatic run_sweep(int which, int inj_at, output res_t o);
    res_t cur;
    int cycles = 0;
    int run5 = 0;
    @(negedge clk) set_start(which, 1'b1);
    @(negedge clk) set_start(which, 1'b0);
    cur = observe(which);
    while (cur.done == 0 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      cur = observe(which);
      if (cur.pi == 5) run5++;
      if (cycles == inj_at) begin
        set_start(which, 1'b1); g_we = 1'b1; g_addr = 7'd1; g_data = 4'd0;
      end else if (cycles == inj_at + 1) begin
        set_start(which, 1'b0); g_we = 1'b0;
      end
    end
    o = cur;
    o.cycles = cycles;
    o.run5 = run5;
  endtask

  task automatic test_sweep(string name, int which, int m, int s, int inj_at);
    res_t o, e;
    mode = m;
    sb.push_back(model_sweep(m, s));
    run_sweep(which, inj_at, o);
    e = sb.pop_front();
    checks++;
    if (o.err !== e.err || o.hd !== e.hd || o.mx !== e.mx || o.fidx !== e.fidx || o.fvalid !== e.fvalid) begin
      errors++;
      $display("FAIL %s metrics: got err=%0d hd=%0d max=%0d fidx=%0d fvalid=%0d, expected err=%0d hd=%0d max=%0d fidx=%0d fvalid=%0d",
               name, o.err, o.hd, o.mx, o.fidx, o.fvalid, e.err, e.hd, e.mx, e.fidx, e.fvalid);
    end
    checks++;
    if (o.cycles !== e.cycles) begin
      errors++;
      $display("FAIL %s cycles: got %0d expected %0d", name, o.cycles, e.cycles);
    end
    checks++;
    if (o.run5 !== e.run5) begin
      errors++;
      $display("FAIL %s pi_hold: got %0d expected %0d", name, o.run5, e.run5);
    end
    checks++;
    if (o.done !== 1 || o.pi !== 127) begin
      errors++;
      $display("FAIL %s done_state: got done=%0d pi=%0d expected done=1 pi=127", name, o.done, o.pi);
    end
  endtask

  task automatic test_reset;
    res_t o;
    for (int w = 0; w < 4; w += 1) begin
      if (w == 2) continue;
      o = observe(w);
      checks++;
      if (o.busy !== 0 || o.done !== 0 || o.pi !== 0 || o.err !== 0 || o.hd !== 0 ||
          o.mx !== 0 || o.fidx !== 0 || o.fvalid !== 0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got busy=%0d done=%0d pi=%0d err=%0d hd=%0d max=%0d fidx=%0d fvalid=%0d expected all 0",
                 w, o.busy, o.done, o.pi, o.err, o.hd, o.mx, o.fidx, o.fvalid);
      end
    end
  endtask

  task automatic load_golden;
    for (int v = 0; v < 128; v++) begin
      @(negedge clk);
      g_we = 1'b1; g_addr = 7'(v); g_data = adder(7'(v));
    end
    @(negedge clk) g_we = 1'b0;
  endtask

  task automatic test_reset_mid;
    res_t o;
    mode = 1;
    @(negedge clk) st1 = 1'b1;
    @(negedge clk) st1 = 1'b0;
    repeat (99) @(negedge clk);
    o = observe(1);
    checks++;
    if (o.busy !== 1) begin
      errors++;
      $display("FAIL mid_sweep_busy: got %0d expected 1", o.busy);
    end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    o = observe(1);
    checks++;
    if (o.busy !== 0 || o.done !== 0 || o.pi !== 0 || o.err !== 0 || o.hd !== 0 ||
        o.mx !== 0 || o.fidx !== 0 || o.fvalid !== 0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%0d done=%0d pi=%0d err=%0d hd=%0d max=%0d fidx=%0d fvalid=%0d expected all 0",
               o.busy, o.done, o.pi, o.err, o.hd, o.mx, o.fidx, o.fvalid);
    end
    test_sweep("rerun_after_rst", 1, 1, 1, -10);
  endtask

  task automatic test_ignore_busy;
    test_sweep("start_we_while_busy", 1, 1, 1, 50);
  endtask

  task automatic test_back_to_back;
    test_sweep("restart_from_done", 1, 1, 1, -10);
  endtask

  initial begin
    rst = 1'b1; st0 = 1'b0; st1 = 1'b0; st3 = 1'b0;
    g_we = 1'b0; g_addr = '0; g_data = '0; mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    load_golden();
    test_sweep("exact", 1, 0, 1, -10);
    test_sweep("settle0", 0, 0, 0, -10);
    test_sweep("settle3", 3, 0, 3, -10);
    test_sweep("bit0_stuck", 1, 1, 1, -10);
    test_sweep("invert_all", 1, 2, 1, -10);
    test_reset_mid();
    test_ignore_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
